// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM encoding and divide special-result constants for alu_seq.
package alu_seq_pkg;

  localparam int unsigned OP_W  = 5;
  localparam int unsigned MAX_W = 64;

  localparam logic [OP_W-1:0] OP_OR   = 5'd0;
  localparam logic [OP_W-1:0] OP_AND  = 5'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 5'd2;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd3;
  localparam logic [OP_W-1:0] OP_NEG  = 5'd4;
  localparam logic [OP_W-1:0] OP_SHR  = 5'd5;
  localparam logic [OP_W-1:0] OP_SHL  = 5'd6;
  localparam logic [OP_W-1:0] OP_ROR  = 5'd7;
  localparam logic [OP_W-1:0] OP_ROL  = 5'd8;
  localparam logic [OP_W-1:0] OP_SHRA = 5'd9;
  localparam logic [OP_W-1:0] OP_MUL  = 5'd10;
  localparam logic [OP_W-1:0] OP_DIV  = 5'd11;
  localparam logic [OP_W-1:0] OP_NOT  = 5'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Quotient returned for a divide by zero; sliced to WIDTH by the user.
  localparam logic [MAX_W-1:0] DIV0_QUO    = '1;
  // Remainder returned for MIN / -1.
  localparam logic [MAX_W-1:0] DIV_OVF_REM = '0;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative engine: radix-2 Booth multiply or restoring divide on magnitudes, one step per cycle.
module alu_seq_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 go,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 last,
  output logic [2*WIDTH-1:0]   prod_or_qr
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic             div_mode;
  logic [WIDTH:0]   hi;      // Booth accumulator (signed, one guard bit) or partial remainder
  logic [WIDTH-1:0] lo;      // multiplier being shifted out, or dividend/quotient shift register
  logic             q_m1;
  logic [WIDTH-1:0] m;       // multiplicand or divisor magnitude

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;

  assign a_mag      = a[WIDTH-1] ? (WIDTH'(0) - a) : a;
  assign b_mag      = b[WIDTH-1] ? (WIDTH'(0) - b) : b;
  assign last       = busy && (cnt == CW'(WIDTH - 1));
  assign prod_or_qr = {hi[WIDTH-1:0], lo};

  // One Booth add/subtract and one restoring trial subtraction, selected by div_mode.
  always_comb begin
    booth_sum = hi;
    unique case ({lo[0], q_m1})
      2'b01:   booth_sum = hi + {m[WIDTH-1], m};
      2'b10:   booth_sum = hi - {m[WIDTH-1], m};
      default: booth_sum = hi;
    endcase
    div_shift = {hi[WIDTH-1:0], lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, m});
    div_diff  = div_shift - {1'b0, m};
  end

  // Load on go, then iterate WIDTH steps with the counter running 0..WIDTH-1.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      busy     <= 1'b0;
      div_mode <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      q_m1     <= 1'b0;
      m        <= '0;
    end else if (go) begin
      busy     <= 1'b1;
      div_mode <= is_div;
      cnt      <= '0;
      hi       <= '0;
      q_m1     <= 1'b0;
      lo       <= is_div ? a_mag : a;
      m        <= is_div ? b_mag : b;
    end else if (busy) begin
      cnt <= last ? '0 : cnt + CW'(1);
      if (last) busy <= 1'b0;
      if (div_mode) begin
        hi <= div_ge ? div_diff : div_shift;
        lo <= {lo[WIDTH-2:0], div_ge};
      end else begin
        hi   <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        lo   <= {booth_sum[0], lo[WIDTH-1:1]};
        q_m1 <= lo[0];
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: registered single-cycle unit plus iterative signed MUL/DIV under start/done.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 start,
  input  logic [OP_W-1:0]      op,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   C,
  output logic                 zero,
  output logic                 neg,
  output logic                 carry,
  output logic                 ovf,
  output logic                 div_zero
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state;
  logic [OP_W-1:0]    op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               sc_valid;

  logic               accept;
  logic               md_go;
  logic               md_busy;
  logic               md_last;
  logic [2*WIDTH-1:0] md_res;

  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;
  logic [WIDTH-1:0]   neg_res;
  logic [2*WIDTH-1:0] rot_r;
  logic [2*WIDTH-1:0] rot_l;
  logic [WIDTH-1:0]   sra_res;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_carry;
  logic               sc_ovf;
  logic [2*WIDTH-1:0] sc_c;

  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [2*WIDTH-1:0] fin_c;
  logic               fin_ovf;
  logic               fin_dz;

  assign accept = start && ready;
  assign md_go  = accept && ((op == OP_MUL) || ((op == OP_DIV) && (B != '0)));

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clock      (clock),
    .clear_n    (clear_n),
    .go         (md_go),
    .is_div     (op == OP_DIV),
    .a          (A),
    .b          (B),
    .busy       (md_busy),
    .last       (md_last),
    .prod_or_qr (md_res)
  );

  assign shamt   = b_q[SHW-1:0];
  assign add_ext = {1'b0, a_q} + {1'b0, b_q};
  assign sub_ext = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
  assign neg_res = WIDTH'(0) - a_q;
  assign rot_r   = {a_q, a_q} >> shamt;
  assign rot_l   = {a_q, a_q} << shamt;
  assign sra_res = $signed(a_q) >>> shamt;
  assign sc_c    = {{WIDTH{sc_res[WIDTH-1]}}, sc_res};

  // Single-cycle result and flags from the operands latched on accept.
  always_comb begin
    sc_res   = a_q & b_q;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (op_q)
      OP_OR:   sc_res = a_q | b_q;
      OP_AND:  sc_res = a_q & b_q;
      OP_ADD: begin
        sc_res   = add_ext[WIDTH-1:0];
        sc_carry = add_ext[WIDTH];
        sc_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res   = sub_ext[WIDTH-1:0];
        sc_carry = sub_ext[WIDTH];
        sc_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_NEG: begin
        sc_res = neg_res;
        sc_ovf = a_q[WIDTH-1] && neg_res[WIDTH-1];
      end
      OP_SHR:  sc_res = a_q >> shamt;
      OP_SHL:  sc_res = a_q << shamt;
      OP_ROR:  sc_res = rot_r[WIDTH-1:0];
      OP_ROL:  sc_res = rot_l[2*WIDTH-1:WIDTH];
      OP_SHRA: sc_res = sra_res;
      OP_NOT:  sc_res = ~a_q;
      default: sc_res = a_q & b_q;
    endcase
  end

  // Final MUL/DIV result: sign fix-up of magnitudes plus the two divide special cases.
  always_comb begin
    quo_s   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? (WIDTH'(0) - md_res[WIDTH-1:0]) : md_res[WIDTH-1:0];
    rem_s   = a_q[WIDTH-1] ? (WIDTH'(0) - md_res[2*WIDTH-1:WIDTH]) : md_res[2*WIDTH-1:WIDTH];
    fin_c   = md_res;
    fin_ovf = 1'b0;
    fin_dz  = 1'b0;
    if (op_q == OP_DIV) begin
      if (b_q == '0) begin
        fin_c  = {a_q, DIV0_QUO[WIDTH-1:0]};
        fin_dz = 1'b1;
      end else if ((a_q == MIN_VAL) && (b_q == '1)) begin
        fin_c   = {DIV_OVF_REM[WIDTH-1:0], MIN_VAL};
        fin_ovf = 1'b1;
      end else begin
        fin_c = {rem_s, quo_s};
      end
    end
  end

  // Control FSM with registered ready/done, result and flags.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state    <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      C        <= '0;
      zero     <= 1'b0;
      neg      <= 1'b0;
      carry    <= 1'b0;
      ovf      <= 1'b0;
      div_zero <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sc_valid <= 1'b0;
    end else begin
      done     <= 1'b0;
      sc_valid <= 1'b0;
      if (sc_valid) begin
        C        <= sc_c;
        zero     <= (sc_c == '0);
        neg      <= sc_c[2*WIDTH-1];
        carry    <= sc_carry;
        ovf      <= sc_ovf;
        div_zero <= 1'b0;
        done     <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q <= op;
            a_q  <= A;
            b_q  <= B;
            if (op == OP_MUL) begin
              state <= MUL;
              ready <= 1'b0;
            end else if (op == OP_DIV) begin
              state <= DIV;
              ready <= 1'b0;
            end else begin
              sc_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          if (md_busy && md_last) state <= FIN;
        end
        DIV: begin
          if ((b_q == '0) || (md_busy && md_last)) state <= FIN;
        end
        FIN: begin
          C        <= fin_c;
          zero     <= (fin_c == '0);
          neg      <= fin_c[2*WIDTH-1];
          carry    <= 1'b0;
          ovf      <= fin_ovf;
          div_zero <= fin_dz;
          done     <= 1'b1;
          state    <= IDLE;
          ready    <= 1'b1;
        end
      endcase
    end
  end

endmodule
